// File: rtl/serdes_8b10b_pkg.sv
// Shared definitions for the 8b10b receive link synchroniser: state encodings,
// the K28.5 comma byte and the set of legal K characters.
package serdes_8b10b_pkg;

  typedef enum logic [1:0] {
    ST_LOS    = 2'd0,
    ST_SYNC   = 2'd1,
    ST_RESYNC = 2'd2
  } sync_state_e;

  localparam logic [7:0] K28_5 = 8'hBC;

  localparam int NUM_LEGAL_K = 12;
  localparam logic [NUM_LEGAL_K-1:0][7:0] LEGAL_K = {
    8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
    8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE
  };

  function automatic logic is_legal_k(input logic [7:0] v);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_LEGAL_K; i++) begin
      if (v == LEGAL_K[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/serdes_8b10b_k_check.sv
// Per-byte K-character screening for one 8-byte rx word: flags K bytes that are
// not legal K characters, and commas that appear outside byte lane 0.
module serdes_8b10b_k_check
  import serdes_8b10b_pkg::*;
(
  input  logic [63:0] i_data,
  input  logic [7:0]  i_k,
  output logic [7:0]  o_illegal_k,
  output logic [7:0]  o_misaligned
);

  always_comb begin
    o_illegal_k  = '0;
    o_misaligned = '0;
    for (int b = 0; b < 8; b++) begin
      o_illegal_k[b]  = i_k[b] & ~is_legal_k(i_data[b*8 +: 8]);
      o_misaligned[b] = (b != 0) && i_k[b] && (i_data[b*8 +: 8] == K28_5);
    end
  end

endmodule

// File: rtl/serdes_8b10b_rx_link_sync.sv
// Link synchronisation state machine for byte-aligned 8b10b rx words, with a
// one-cycle registered data path and saturating error/loss statistics.
module serdes_8b10b_rx_link_sync
  import serdes_8b10b_pkg::*;
#(
  parameter int SYNC_CNT    = 4,
  parameter int LOSS_CNT    = 4,
  parameter int RECOVER_CNT = 16
) (
  input  logic        I_rx_clk,
  input  logic        I_rst_n,
  input  logic [63:0] I_rx_data,
  input  logic [7:0]  I_rx_k_ctrl,
  input  logic        I_cnt_clr,
  output logic [63:0] O_rx_data,
  output logic [7:0]  O_rx_k_ctrl,
  output logic        O_rx_vld,
  output logic        O_link_up,
  output logic [1:0]  O_sync_state,
  output logic [15:0] O_code_err_cnt,
  output logic [7:0]  O_los_cnt
);

  localparam int GW = $clog2(SYNC_CNT + 1);
  localparam int EW = $clog2(LOSS_CNT + 1);
  localparam int RW = $clog2(RECOVER_CNT + 1);

  sync_state_e r_state, w_state_nxt;
  logic [GW-1:0] r_good_cnt, w_good_nxt, w_good_inc;
  logic [EW-1:0] r_err_cnt, w_err_nxt, w_err_inc;
  logic [RW-1:0] r_rec_cnt, w_rec_nxt, w_rec_inc;
  logic          w_los_evt;

  logic [7:0]  w_illegal_k, w_misaligned;
  logic        w_err_word, w_comma;

  logic [63:0] r_rx_data;
  logic [7:0]  r_rx_k_ctrl;
  logic        r_rx_vld;
  logic [15:0] r_code_err_cnt;
  logic [7:0]  r_los_cnt;

  serdes_8b10b_k_check u_k_check (
    .i_data       (I_rx_data),
    .i_k          (I_rx_k_ctrl),
    .o_illegal_k  (w_illegal_k),
    .o_misaligned (w_misaligned)
  );

  // A comma that is also an error word is treated purely as an error.
  assign w_err_word = |(w_illegal_k | w_misaligned);
  assign w_comma    = I_rx_k_ctrl[0] && (I_rx_data[7:0] == K28_5);

  assign w_good_inc = r_good_cnt + GW'(1);
  assign w_err_inc  = r_err_cnt + EW'(1);
  assign w_rec_inc  = r_rec_cnt + RW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_err_nxt   = r_err_cnt;
    w_rec_nxt   = r_rec_cnt;
    w_los_evt   = 1'b0;
    case (r_state)
      ST_LOS: begin
        if (w_err_word) begin
          w_good_nxt = '0;
        end else if (w_comma) begin
          if (w_good_inc == GW'(SYNC_CNT)) begin
            w_state_nxt = ST_SYNC;
            w_good_nxt  = '0;
          end else begin
            w_good_nxt = w_good_inc;
          end
        end
      end
      ST_SYNC: begin
        if (w_err_word) begin
          w_state_nxt = ST_RESYNC;
          w_err_nxt   = EW'(1);
          w_rec_nxt   = '0;
        end
      end
      ST_RESYNC: begin
        if (w_err_word) begin
          w_rec_nxt = '0;
          if (w_err_inc == EW'(LOSS_CNT)) begin
            w_state_nxt = ST_LOS;
            w_err_nxt   = '0;
            w_los_evt   = 1'b1;
          end else begin
            w_err_nxt = w_err_inc;
          end
        end else if (w_rec_inc == RW'(RECOVER_CNT)) begin
          w_state_nxt = ST_SYNC;
          w_err_nxt   = '0;
          w_rec_nxt   = '0;
        end else begin
          w_rec_nxt = w_rec_inc;
        end
      end
      default: begin
        w_state_nxt = ST_LOS;
        w_good_nxt  = '0;
        w_err_nxt   = '0;
        w_rec_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge I_rx_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state    <= ST_LOS;
      r_good_cnt <= '0;
      r_err_cnt  <= '0;
      r_rec_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_err_cnt  <= w_err_nxt;
      r_rec_cnt  <= w_rec_nxt;
    end
  end

  // Valid reflects the link state at the moment the word arrived.
  always_ff @(posedge I_rx_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_rx_data   <= '0;
      r_rx_k_ctrl <= '0;
      r_rx_vld    <= 1'b0;
    end else begin
      r_rx_data   <= I_rx_data;
      r_rx_k_ctrl <= I_rx_k_ctrl;
      r_rx_vld    <= (r_state != ST_LOS);
    end
  end

  always_ff @(posedge I_rx_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_code_err_cnt <= '0;
      r_los_cnt      <= '0;
    end else if (I_cnt_clr) begin
      r_code_err_cnt <= '0;
      r_los_cnt      <= '0;
    end else begin
      if (w_err_word && (r_code_err_cnt != 16'hFFFF)) r_code_err_cnt <= r_code_err_cnt + 16'd1;
      if (w_los_evt && (r_los_cnt != 8'hFF))           r_los_cnt      <= r_los_cnt + 8'd1;
    end
  end

  assign O_rx_data      = r_rx_data;
  assign O_rx_k_ctrl    = r_rx_k_ctrl;
  assign O_rx_vld       = r_rx_vld;
  assign O_link_up      = (r_state != ST_LOS);
  assign O_sync_state   = r_state;
  assign O_code_err_cnt = r_code_err_cnt;
  assign O_los_cnt      = r_los_cnt;

endmodule

// File: tb/tb_serdes_8b10b_rx_link_sync.sv
// Bench for serdes_8b10b_rx_link_sync: directed link scenarios plus random word
// streams, checked every cycle against a word-level behavioural model.
module tb_serdes_8b10b_rx_link_sync;

  localparam int SYNC_N = 4;
  localparam int LOSS_N = 4;
  localparam int REC_N  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] tb_data = '0;
  logic [7:0]  tb_k = '0;
  logic        tb_clr = 1'b0;

  logic [63:0] o_data;
  logic [7:0]  o_k;
  logic        o_vld, o_link;
  logic [1:0]  o_state;
  logic [15:0] o_cec;
  logic [7:0]  o_losc;

  int n_checks = 0;
  int n_errs   = 0;

  serdes_8b10b_rx_link_sync #(
    .SYNC_CNT(SYNC_N), .LOSS_CNT(LOSS_N), .RECOVER_CNT(REC_N)
  ) dut (
    .I_rx_clk      (clk),
    .I_rst_n       (rst_n),
    .I_rx_data     (tb_data),
    .I_rx_k_ctrl   (tb_k),
    .I_cnt_clr     (tb_clr),
    .O_rx_data     (o_data),
    .O_rx_k_ctrl   (o_k),
    .O_rx_vld      (o_vld),
    .O_link_up     (o_link),
    .O_sync_state  (o_state),
    .O_code_err_cnt(o_cec),
    .O_los_cnt     (o_losc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (word-level, spec rules) ----------------
  logic [7:0] legal_k [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                               8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  function automatic bit in_legal(input logic [7:0] v);
    foreach (legal_k[i]) if (legal_k[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit word_is_err(input logic [63:0] d, input logic [7:0] k);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) begin
      v = d[b*8 +: 8];
      if (k[b] && !in_legal(v)) return 1'b1;
      if (k[b] && b > 0 && v == 8'hBC) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Link modes: 0 = lost, 1 = synced, 2 = resyncing
  int          m_mode = 0;
  int          m_good = 0, m_bad = 0, m_clean = 0;
  int          m_cec = 0, m_losc = 0;
  logic [63:0] m_data = '0;
  logic [7:0]  m_k = '0;
  bit          m_vld = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_good = 0; m_bad = 0; m_clean = 0;
      m_cec = 0; m_losc = 0; m_data = '0; m_k = '0; m_vld = 1'b0;
    end else begin
      bit e, c, lost_now;
      e = word_is_err(tb_data, tb_k);
      c = tb_k[0] && (tb_data[7:0] == 8'hBC);
      lost_now = 1'b0;
      m_data = tb_data;
      m_k    = tb_k;
      m_vld  = (m_mode != 0);
      if (m_mode == 0) begin
        if (e) m_good = 0;
        else if (c) m_good++;
        if (m_good == SYNC_N) begin m_mode = 1; m_good = 0; end
      end else if (m_mode == 1) begin
        if (e) begin m_mode = 2; m_bad = 1; m_clean = 0; end
      end else begin
        if (e) begin
          m_bad++; m_clean = 0;
          if (m_bad == LOSS_N) begin m_mode = 0; m_bad = 0; lost_now = 1'b1; end
        end else begin
          m_clean++;
          if (m_clean == REC_N) begin m_mode = 1; m_bad = 0; m_clean = 0; end
        end
      end
      if (tb_clr) begin
        m_cec = 0; m_losc = 0;
      end else begin
        if (e && m_cec < 65535) m_cec++;
        if (lost_now && m_losc < 255) m_losc++;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    chk("rx_data",  o_data,  m_data);
    chk("rx_k",     o_k,     m_k);
    chk("rx_vld",   o_vld,   m_vld);
    chk("link_up",  o_link,  (m_mode != 0));
    chk("state",    o_state, m_mode);
    chk("code_err", o_cec,   m_cec);
    chk("los_cnt",  o_losc,  m_losc);
  end

  // ---------------- stimulus ----------------
  task automatic word(input logic [63:0] d, input logic [7:0] k, input logic clr);
    tb_data = d; tb_k = k; tb_clr = clr;
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic comma();
    logic [63:0] d;
    d = rnd64(); d[7:0] = 8'hBC;
    word(d, 8'h01, 1'b0);
  endtask

  task automatic bad55(input logic clr);
    logic [63:0] d;
    d = rnd64(); d[7:0] = 8'h55;
    word(d, 8'h01, clr);
  endtask

  task automatic misaligned();
    logic [63:0] d;
    d = rnd64(); d[23:16] = 8'hBC;
    word(d, 8'h04, 1'b0);
  endtask

  task automatic rnd_word(input int err_pct);
    logic [63:0] d;
    logic [7:0]  k, v;
    int r, b;
    d = rnd64(); k = 8'h00;
    r = $urandom_range(0, 99);
    b = $urandom_range(0, 7);
    if (r < err_pct / 2) begin
      v = $urandom_range(0, 255);
      d[b*8 +: 8] = v; k[b] = 1'b1;
    end else if (r < err_pct) begin
      b = $urandom_range(1, 7);
      d[b*8 +: 8] = 8'hBC; k[b] = 1'b1;
    end else if (r < err_pct + 35) begin
      d[7:0] = 8'hBC; k = 8'h01;
    end else if (r < err_pct + 45) begin
      v = legal_k[$urandom_range(0, 11)];
      if (b > 0 && v == 8'hBC) v = 8'h1C;
      d[b*8 +: 8] = v; k[b] = 1'b1;
    end
    word(d, k, ($urandom_range(0, 39) == 0));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("reset_state", o_state, 2'd0);
    chk("reset_link",  o_link,  1'b0);
    chk("reset_vld",   o_vld,   1'b0);
    chk("reset_data",  o_data,  64'h0);
    chk("reset_cec",   o_cec,   16'h0);
    chk("reset_losc",  o_losc,  8'h0);
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;

    // Acquisition: four commas.
    repeat (3) comma();
    chk("acq_still_los", o_state, 2'd0);
    comma();
    chk("acq_sync_state", o_state, 2'd1);
    chk("acq_link_up",    o_link,  1'b1);
    chk("acq_vld_4th",    o_vld,   1'b0);
    word(rnd64(), 8'h00, 1'b0);
    chk("acq_vld_next",   o_vld,   1'b1);

    // Single bad K in SYNC, then recovery.
    bad55(1'b0);
    chk("resync_state", o_state, 2'd2);
    chk("resync_cec",   o_cec,   16'd1);
    repeat (15) word(rnd64(), 8'h00, 1'b0);
    chk("recover_15",   o_state, 2'd2);
    word(rnd64(), 8'h00, 1'b0);
    chk("recover_16",   o_state, 2'd1);

    // Four misaligned commas drop the link.
    repeat (4) misaligned();
    chk("los_state", o_state, 2'd0);
    chk("los_link",  o_link,  1'b0);
    chk("los_cnt1",  o_losc,  8'd1);
    chk("los_cec",   o_cec,   16'd5);
    word(rnd64(), 8'h00, 1'b0);
    chk("los_vld",   o_vld,   1'b0);

    // Error interrupts comma run.
    repeat (3) comma();
    bad55(1'b0);
    repeat (3) comma();
    chk("interrupt_los", o_state, 2'd0);
    comma();
    chk("interrupt_sync", o_state, 2'd1);

    // Asynchronous reset while resyncing.
    bad55(1'b0);
    chk("pre_rst_resync", o_state, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", o_state, 2'd0);
    chk("arst_link",  o_link,  1'b0);
    chk("arst_vld",   o_vld,   1'b0);
    chk("arst_data",  o_data,  64'h0);
    chk("arst_k",     o_k,     8'h0);
    chk("arst_cec",   o_cec,   16'h0);
    chk("arst_losc",  o_losc,  8'h0);
    @(posedge clk); #3 rst_n = 1'b1;
    comma();
    chk("post_rst_vld", o_vld, 1'b0);

    // Random streams in alternating low/high error phases.
    for (int i = 0; i < 2000; i++) begin
      rnd_word(((i / 250) % 2) ? 16 : 3);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end

    // Loss counter saturation.
    for (int i = 0; i < 260; i++) begin
      repeat (SYNC_N) comma();
      repeat (LOSS_N) misaligned();
    end
    chk("losc_sat", o_losc, 8'hFF);

    // Code error counter saturation, then clear against a coincident error.
    repeat (65540) bad55(1'b0);
    chk("cec_sat", o_cec, 16'hFFFF);
    bad55(1'b0);
    chk("cec_hold", o_cec, 16'hFFFF);
    bad55(1'b1);
    chk("cec_clr",  o_cec, 16'h0);
    chk("losc_clr", o_losc, 8'h0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
